// File: rtl/mg_key_mix_if.sv
`default_nettype none
// ============================================================================
// Module      : mg_key_mix_if
// Description : Handshake bundle for the MacGuffin key-mix stage.
//               Upstream side: in_valid/in_ready carry in_block, in_key and
//               in_tag. Downstream side: out_valid/out_ready carry out_data,
//               out_x0 and out_tag.
//               master : the environment (drives in_*, out_ready)
//               slave  : the key-mix stage (drives in_ready, out_*)
//               TAG_W must match the TAG_W of the attached mg_key_mix.
// Revision    : 1.0 - initial release
// ============================================================================
interface mg_key_mix_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_block;
    logic [47:0]      in_key;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [47:0]      out_data;
    logic [15:0]      out_x0;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_block, in_key, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_x0, out_tag
    );

    modport slave (
        input  in_valid, in_block, in_key, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_x0, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/mg_key_mix.sv
`default_nettype none
// ============================================================================
// Module      : mg_key_mix
// Description : MacGuffin key-mix pipeline stage. XORs the three round-key
//               words into block words x1..x3 and registers the 48-bit result
//               for the downstream F-function permutation; x0 and the round
//               tag ride along as sideband. A main register plus one skid
//               entry give full throughput with a registered in_ready.
// Ports       : clk, rst (async, active-high)
//               bus        - mg_key_mix_if.slave (in_* / out_* handshake)
//               xfer_count - 16-bit output transfer count (only when
//                            MG_KEY_MIX_STATS_EN is defined)
// Options     : `define MG_KEY_MIX_STATS_EN to add the xfer_count port.
// Revision    : 1.0 - initial release
// ============================================================================
module mg_key_mix #(
    parameter int TAG_W = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mg_key_mix_if.slave bus
`ifdef MG_KEY_MIX_STATS_EN
    ,
    output logic [15:0] xfer_count
`endif
);

    // Occupancy: EMPTY = M invalid, ONE = M valid, FULL = M and S valid.
    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [47:0]      r_m_data;
    logic [15:0]      r_m_x0;
    logic [TAG_W-1:0] r_m_tag;
    logic [47:0]      r_s_data;
    logic [15:0]      r_s_x0;
    logic [TAG_W-1:0] r_s_tag;
    logic [47:0]      w_mix;
    logic             w_accept;

    // {x1^k0, x2^k1, x3^k2}: plain per-word XOR, no rotation or carry.
    assign w_mix = {bus.in_block[47:32] ^ bus.in_key[47:32],
                    bus.in_block[31:16] ^ bus.in_key[31:16],
                    bus.in_block[15:0]  ^ bus.in_key[15:0]};

    assign w_accept = bus.in_valid & r_in_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_empty: if (w_accept) w_next_state = c_st_one;
            c_st_one: begin
                if (w_accept && !bus.out_ready)      w_next_state = c_st_full;
                else if (!w_accept && bus.out_ready) w_next_state = c_st_empty;
            end
            c_st_full:  if (bus.out_ready) w_next_state = c_st_one;
            default:    w_next_state = c_st_empty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_empty;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_m_data    <= '0;
            r_m_x0      <= '0;
            r_m_tag     <= '0;
            r_s_data    <= '0;
            r_s_x0      <= '0;
            r_s_tag     <= '0;
        end else begin
            r_state     <= w_next_state;
            // Registered handshake flags are derived from the next occupancy,
            // so in_ready drops in the same cycle the skid entry fills.
            r_in_ready  <= (w_next_state != c_st_full);
            r_out_valid <= (w_next_state != c_st_empty);
            case (r_state)
                c_st_empty: begin
                    if (w_accept) begin
                        r_m_data <= w_mix;
                        r_m_x0   <= bus.in_block[63:48];
                        r_m_tag  <= bus.in_tag;
                    end
                end
                c_st_one: begin
                    if (w_accept && bus.out_ready) begin
                        r_m_data <= w_mix;
                        r_m_x0   <= bus.in_block[63:48];
                        r_m_tag  <= bus.in_tag;
                    end else if (w_accept) begin
                        // M is stalled: park the newcomer behind it.
                        r_s_data <= w_mix;
                        r_s_x0   <= bus.in_block[63:48];
                        r_s_tag  <= bus.in_tag;
                    end
                end
                c_st_full: begin
                    // in_ready is low here, so the skid entry is the only
                    // candidate for M; this keeps strict FIFO order.
                    if (bus.out_ready) begin
                        r_m_data <= r_s_data;
                        r_m_x0   <= r_s_x0;
                        r_m_tag  <= r_s_tag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_m_data;
    assign bus.out_x0    = r_m_x0;
    assign bus.out_tag   = r_m_tag;

`ifdef MG_KEY_MIX_STATS_EN
    logic [15:0] r_xfer_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_count <= '0;
        end else if (r_out_valid && bus.out_ready) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

    assign xfer_count = r_xfer_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mg_key_mix.sv
`default_nettype none
// ============================================================================
// Module      : tb_mg_key_mix
// Description : Self-checking bench for mg_key_mix. Accepted transfers are
//               pushed into an expected queue by a word-level model; a monitor
//               pops and compares on every output transfer and checks the
//               handshake flags against the queue occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mg_key_mix;
    localparam int TAG_W = 4;

    typedef struct {
        logic [47:0]      data;
        logic [15:0]      x0;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   chk_en  = 1'b0;
    bit   prev_stall = 1'b0;
    exp_t prev_out;
    exp_t q[$];
    int unsigned model_cnt = 0;
    bit   rand_done;

`ifdef MG_KEY_MIX_STATS_EN
    logic [15:0] xfer_count;
`endif

    mg_key_mix_if #(.TAG_W(TAG_W)) bus ();

    mg_key_mix #(.TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MG_KEY_MIX_STATS_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: split into 16-bit words and XOR word i of the key into
    // block word i+1.
    function automatic exp_t model(input logic [63:0] blk, input logic [47:0] key,
                                   input logic [TAG_W-1:0] tag);
        exp_t e;
        logic [15:0] xw [4];
        logic [15:0] kw [3];
        for (int i = 0; i < 4; i++) xw[i] = 16'(blk >> (16 * (3 - i)));
        for (int i = 0; i < 3; i++) kw[i] = 16'(key >> (16 * (2 - i)));
        e.data = {xw[1] ^ kw[0], xw[2] ^ kw[1], xw[3] ^ kw[2]};
        e.x0   = xw[0];
        e.tag  = tag;
        return e;
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
            if (prev_stall) begin
                check("hold_data", 64'(bus.out_data), 64'(prev_out.data));
                check("hold_x0", 64'(bus.out_x0), 64'(prev_out.x0));
                check("hold_tag", 64'(bus.out_tag), 64'(prev_out.tag));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(e.data));
                    check("out_x0", 64'(bus.out_x0), 64'(e.x0));
                    check("out_tag", 64'(bus.out_tag), 64'(e.tag));
                end
                model_cnt++;
            end
            prev_stall    = bus.out_valid && !bus.out_ready;
            prev_out.data = bus.out_data;
            prev_out.x0   = bus.out_x0;
            prev_out.tag  = bus.out_tag;
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_block, bus.in_key, bus.in_tag));
        end
    end

    // Drive one transfer and hold it until accepted (bounded).
    task automatic send(input logic [63:0] blk, input logic [47:0] key, input logic [TAG_W-1:0] tag);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_block = blk;
        bus.in_key   = key;
        bus.in_tag   = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain", 64'(q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [47:0] a_data;
        logic [47:0] b_data;

        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.in_key    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        #3;
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 64'(bus.in_ready), 64'(1));
        chk_en = 1'b1;

        // Basic mix.
        bus.out_ready = 1'b1;
        send(64'h0123_4567_89AB_CDEF, 48'hFFFF_0000_1234, 4'd3);
        @(negedge clk);
        check("basic_valid", 64'(bus.out_valid), 64'(1));
        check("basic_data", 64'(bus.out_data), 64'h0000_BA98_89AB_DFDB);
        check("basic_x0", 64'(bus.out_x0), 64'h0123);
        check("basic_tag", 64'(bus.out_tag), 64'd3);
        @(posedge clk);
        #1;

        // Zero key.
        send(64'hFFFF_AAAA_5555_0F0F, 48'h0, 4'd9);
        @(negedge clk);
        check("zero_key_data", 64'(bus.out_data), 64'h0000_AAAA_5555_0F0F);
        check("zero_key_x0", 64'(bus.out_x0), 64'hFFFF);
        @(posedge clk);
        #1;

        // Streaming: 8 back-to-back; monitor checks in_ready stays high.
        for (int i = 0; i < 8; i++)
            send({$urandom, $urandom}, 48'({$urandom, $urandom}), 4'(i));
        drain();

        // Stall / skid.
        bus.out_ready = 1'b0;
        a_data = model(64'h1111_2222_3333_4444, 48'hAAAA_BBBB_CCCC, 4'd1).data;
        b_data = model(64'h5555_6666_7777_8888, 48'h0F0F_F0F0_1234, 4'd2).data;
        send(64'h1111_2222_3333_4444, 48'hAAAA_BBBB_CCCC, 4'd1);
        send(64'h5555_6666_7777_8888, 48'h0F0F_F0F0_1234, 4'd2);
        @(negedge clk);
        check("full_in_ready", 64'(bus.in_ready), 64'(0));
        check("full_data_a", 64'(bus.out_data), 64'(a_data));
        // Offer a third item while FULL: must be ignored.
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_block = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("skid_first_a", 64'(bus.out_data), 64'(a_data));
        @(negedge clk);
        check("skid_second_b", 64'(bus.out_data), 64'(b_data));
        check("skid_in_ready_back", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        drain();

        // Randomized traffic with random backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send({$urandom, $urandom}, 48'({$urandom, $urandom}), 4'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        // Asynchronous reset while FULL.
        bus.out_ready = 1'b0;
        send(64'hAAAA_0000_1111_2222, 48'h1, 4'd5);
        send(64'hBBBB_3333_4444_5555, 48'h2, 4'd6);
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'(0));
        check("arst_in_ready", 64'(bus.in_ready), 64'(0));
        check("arst_out_data", 64'(bus.out_data), 64'(0));
        q.delete();
        prev_stall = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("arst_release_in_ready", 64'(bus.in_ready), 64'(1));
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(64'h0123_4567_89AB_CDEF, 48'hFFFF_0000_1234, 4'd7);
        drain();

`ifdef MG_KEY_MIX_STATS_EN
        check("stats_count", 64'(xfer_count), 64'(model_cnt[15:0]));
        chk_en = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        q.delete();
        prev_stall = 1'b0;
        model_cnt = 0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 65537; i++)
            send(64'(i), 48'(i), 4'(i));
        drain();
        check("stats_wrap", 64'(xfer_count), 64'h0001);
        #2 rst = 1'b1;
        #1;
        check("stats_rst", 64'(xfer_count), 64'h0000);
        rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
